if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the RISC-V pipeline. It directly feeds the byte-addressed, combinational-read instruction memory.
- Holds the PC and drives Inst_Address. It captures the returned 32-bit word into the IF/ID pipeline register.
- Handles stalls, branch/jump redirects, end-of-program halt and misaligned-target faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PROG_END, 32'd188, first byte address past the program; fetch at or beyond it halts.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit hold; freezes PC and IF/ID.
- redirect  in  1  taken branch/jal/jalr resolved downstream.
- redirect_target  in  32  new PC on redirect.
- Instruction  in  32  word returned by instruction memory for Inst_Address (same cycle).
- Inst_Address  out  32  current PC to instruction memory.
- if_id_pc  out  32  PC of the instruction in IF/ID.
- if_id_instr  out  32  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch has stopped at PROG_END.
- fetch_fault  out  1  sticky misaligned-redirect fault.
- fetch_count  out  32  number of instructions delivered into IF/ID (valid=1 captures).

Behaviour:
- Reset is asynchronous and active-low. All registered state resets immediately on reset_n=0:
  - PC=RESET_PC, state=RUN.
  - if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0.
  - halted=0, fetch_fault=0, fetch_count=0.
- Reset assertion mid-operation discards all in-flight state. The first fetch after deassertion is from RESET_PC.
- Inst_Address = PC at all times, combinationally. Instruction memory reads the word the same cycle, giving 1-cycle latency from PC to IF/ID.
- State machine has three states: RUN, HALT and FAULT. halted=(state==HALT); fetch_fault=(state==FAULT).
- Per-edge priority, evaluated in RUN or HALT:
  - Priority 1 — redirect=1, target[1:0]!=0:
    - state<=FAULT; PC unchanged.
    - IF/ID <= bubble (valid=0, instr=NOP_INSTR, pc unchanged).
  - Priority 2 — redirect=1, target aligned:
    - PC<=redirect_target; IF/ID<=bubble.
    - state<=RUN, even from HALT, because an older in-flight branch may legally leave the halt region.
    - redirect overrides a simultaneous stall.
  - Priority 3 — stall=1: PC, IF/ID, state and fetch_count all hold.
  - Priority 4 — normal, RUN with PC<PROG_END:
    - if_id_instr<=Instruction, if_id_pc<=PC, if_id_valid<=1.
    - PC<=PC+4; fetch_count<=fetch_count+1.
  - Priority 5 — normal, RUN with PC>=PROG_END:
    - state<=HALT; PC holds; IF/ID<=bubble.
    - Instruction is ignored (memory beyond PROG_END is undefined).
  - Priority 6 — normal, HALT: PC holds; IF/ID<=bubble each cycle.
- FAULT: PC and fetch_count frozen; IF/ID<=bubble every cycle. Exit is only via reset; redirect and stall are ignored.
- Arithmetic is 32-bit unsigned:
  - PC+4 wraps modulo 2^32 (unreachable when PROG_END is below the wrap point).
  - PROG_END comparison is unsigned.
  - fetch_count wraps modulo 2^32.
- A bubble never increments fetch_count. if_id_valid=0 always pairs with if_id_instr=NOP_INSTR.

Test Plan:
- Reset then run 3 cycles with stall=0, redirect=0:
  - Inst_Address = 0, 4, 8, 12.
  - IF/ID gets (pc0, 0x10000513), (pc4, 0x00553023), (pc8, 0x00653423).
  - fetch_count=3.
- Stall held 2 cycles at PC=8: Inst_Address stays 8; IF/ID keeps (pc4, 0x00553023), valid=1; fetch_count unchanged. Release resumes at 8.
- redirect=1, target=0x40, with stall=1 in the same cycle: next Inst_Address=0x40, if_id_valid=0, if_id_instr=0x00000013. Following cycle IF/ID=(0x40, memory word at 0x40).
- Run sequentially to PC=188:
  - halted=1 the cycle after PC reaches 188; Inst_Address holds 188; valid stays 0.
  - A later redirect to 0x64 clears halted and fetches from 0x64.
- redirect with target=0x42:
  - fetch_fault=1 and sticky; PC unchanged; bubbles forever.
  - Further aligned redirects are ignored; only reset_n=0 clears the fault.
- Assert reset_n=0 asynchronously mid-cycle at PC=0x2C: all outputs go to reset values before the next clk edge; after release, fetch restarts at 0.

Source files
------------

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RISC-V instruction-fetch stage with stall, redirect, halt and fault handling
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PROG_END  = 32'd188,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic [31:0] Instruction,
  output logic [31:0] Inst_Address,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;

    if (state_q == S_FAULT) begin
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
    end else if (redirect && (redirect_target[1:0] != 2'b00)) begin
      state_d       = S_FAULT;
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
    end else if (redirect) begin
      // An older branch may legally leave the halt region, so redirect also resumes RUN.
      pc_d          = redirect_target;
      state_d       = S_RUN;
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
    end else if (!stall) begin
      if ((state_q == S_RUN) && (pc_q < PROG_END)) begin
        if_id_pc_d    = pc_q;
        if_id_instr_d = Instruction;
        if_id_valid_d = 1'b1;
        pc_d          = pc_q + 32'd4;
        fetch_count_d = fetch_count_q + 32'd1;
      end else begin
        state_d       = S_HALT;
        if_id_valid_d = 1'b0;
        if_id_instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_RUN;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'd0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign Inst_Address = pc_q;
  assign if_id_pc     = if_id_pc_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_valid  = if_id_valid_q;
  assign halted       = (state_q == S_HALT);
  assign fetch_fault  = (state_q == S_FAULT);
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage against a behavioural fetch model
module tb_if_stage;

  localparam logic [31:0] PROG_END = 32'd188;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] Instruction;
  logic [31:0] Inst_Address;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_pass   = 0;

  if_stage dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .Instruction(Instruction),
    .Inst_Address(Inst_Address), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_fault(fetch_fault),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr >= PROG_END) return 32'hDEAD_BEEF;
    case (addr)
      32'd0:   return 32'h1000_0513;
      32'd4:   return 32'h0055_3023;
      32'd8:   return 32'h0065_3423;
      default: return 32'hC0DE_0000 | addr;
    endcase
  endfunction

  assign Instruction = mem_word(Inst_Address);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: PC, mode flags and the IF/ID contents as plain variables.
  logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
  logic        m_valid, m_halt, m_fault;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc = 32'd0; m_ipc = 32'd0; m_instr = NOP; m_cnt = 32'd0;
      m_valid = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
    end else if (m_fault) begin
      m_valid = 1'b0; m_instr = NOP;
    end else if (redirect && redirect_target % 4 != 0) begin
      m_fault = 1'b1; m_valid = 1'b0; m_instr = NOP;
    end else if (redirect) begin
      m_pc = redirect_target; m_halt = 1'b0; m_valid = 1'b0; m_instr = NOP;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (m_halt || m_pc >= PROG_END) begin
      m_halt = 1'b1; m_valid = 1'b0; m_instr = NOP;
    end else begin
      m_ipc = m_pc; m_instr = mem_word(m_pc); m_valid = 1'b1;
      m_pc = m_pc + 4; m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    chk("m_addr",  Inst_Address, m_pc);
    chk("m_pc",    if_id_pc,     m_ipc);
    chk("m_instr", if_id_instr,  m_instr);
    chk("m_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    chk("m_halt",  {31'd0, halted},      {31'd0, m_halt});
    chk("m_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    chk("m_count", fetch_count,  m_cnt);
  end

  task automatic edge_then_drive;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_addr",  Inst_Address, 32'd0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_count", fetch_count, 32'd0);

    edge_then_drive;
    chk("f0_addr",  Inst_Address, 32'd4);
    chk("f0_instr", if_id_instr,  32'h1000_0513);
    edge_then_drive;
    chk("f1_addr",  Inst_Address, 32'd8);
    chk("f1_pc",    if_id_pc,     32'd4);

    stall = 1'b1;
    repeat (2) edge_then_drive;
    chk("st_addr",  Inst_Address, 32'd8);
    chk("st_instr", if_id_instr,  32'h0055_3023);
    chk("st_valid", {31'd0, if_id_valid}, 32'd1);
    chk("st_count", fetch_count,  32'd2);
    stall = 1'b0;
    edge_then_drive;
    chk("f2_instr", if_id_instr,  32'h0065_3423);
    chk("f2_addr",  Inst_Address, 32'd12);
    chk("f2_count", fetch_count,  32'd3);

    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h40;
    edge_then_drive;
    stall = 1'b0; redirect = 1'b0;
    chk("rd_addr",  Inst_Address, 32'h40);
    chk("rd_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rd_instr", if_id_instr,  NOP);
    edge_then_drive;
    chk("rd_pc",    if_id_pc,     32'h40);
    chk("rd_word",  if_id_instr,  32'hC0DE_0040);

    for (int i = 0; i < 100 && Inst_Address != PROG_END; i++) @(negedge clk);
    chk("reach_end", Inst_Address, PROG_END);
    chk("end_pc",    if_id_pc,     32'd184);
    chk("end_halt0", {31'd0, halted}, 32'd0);
    edge_then_drive;
    chk("halt",      {31'd0, halted}, 32'd1);
    chk("halt_addr", Inst_Address, PROG_END);
    chk("halt_val",  {31'd0, if_id_valid}, 32'd0);
    chk("halt_cnt",  fetch_count, 32'd34);
    repeat (2) edge_then_drive;
    chk("halt_hold", Inst_Address, PROG_END);

    redirect = 1'b1; redirect_target = 32'h64;
    edge_then_drive;
    redirect = 1'b0;
    chk("unhalt",    {31'd0, halted}, 32'd0);
    chk("unh_addr",  Inst_Address, 32'h64);
    edge_then_drive;
    chk("unh_word",  if_id_instr, 32'hC0DE_0064);
    chk("unh_cnt",   fetch_count, 32'd35);

    redirect = 1'b1; redirect_target = 32'h42;
    edge_then_drive;
    chk("flt",       {31'd0, fetch_fault}, 32'd1);
    chk("flt_addr",  Inst_Address, 32'h68);
    redirect_target = 32'h10; stall = 1'b1;
    repeat (3) edge_then_drive;
    redirect = 1'b0; stall = 1'b0;
    repeat (2) edge_then_drive;
    chk("flt_stick", {31'd0, fetch_fault}, 32'd1);
    chk("flt_addr2", Inst_Address, 32'h68);
    chk("flt_val",   {31'd0, if_id_valid}, 32'd0);
    chk("flt_cnt",   fetch_count, 32'd35);

    #1 reset_n = 1'b0;
    edge_then_drive;
    reset_n = 1'b1;
    repeat (11) edge_then_drive;
    chk("pre_rst",   Inst_Address, 32'h2C);
    #1 reset_n = 1'b0;
    #1;
    chk("ar_addr",   Inst_Address, 32'd0);
    chk("ar_pc",     if_id_pc,     32'd0);
    chk("ar_instr",  if_id_instr,  NOP);
    chk("ar_valid",  {31'd0, if_id_valid}, 32'd0);
    chk("ar_count",  fetch_count,  32'd0);
    chk("ar_fault",  {31'd0, fetch_fault}, 32'd0);
    edge_then_drive;
    reset_n = 1'b1;
    edge_then_drive;
    chk("rs_pc",     if_id_pc,     32'd0);
    chk("rs_instr",  if_id_instr,  32'h1000_0513);
    chk("rs_addr",   Inst_Address, 32'd4);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
